// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Captures one upstream transaction when idle. It then either issues a
// single memory read or write, or passes a non-memory op straight through.
// The result is held for the next stage until that stage accepts it.
//
// Ports
//   clk, arst_n            clock, asynchronous active-low reset
//   rdy / free             upstream valid / this stage can accept (IDLE only)
//   pc_i, ar_i, ir_i, ibr_i  upstream PC, accumulator, instruction, operand buffer
//   mem_read, mem_write    memory opcode class of the incoming transaction
//   addr_sel               0: address from ibr_i, 1: address from ar_i
//   pc_o, ar_o, ir_o, ibr_o  registered copies for the next stage
//   rd_data_o              load data (0 for stores, aborts and non-memory ops)
//   err_o                  transaction aborted (timeout or read+write together)
//   rdy_next / free_next   output valid / downstream can accept
//   mem_addr, mem_data_o, mem_we, mem_req, mem_data_i, mem_ack  memory port
module mem_stage #(
   parameter int DW      = 8,
   parameter int AW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          rdy,
   output logic          free,
   input  logic [AW-1:0] pc_i,
   input  logic [DW-1:0] ar_i,
   input  logic [7:0]    ir_i,
   input  logic [DW-1:0] ibr_i,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic          addr_sel,
   output logic [AW-1:0] pc_o,
   output logic [DW-1:0] ar_o,
   output logic [7:0]    ir_o,
   output logic [DW-1:0] ibr_o,
   output logic [DW-1:0] rd_data_o,
   output logic          err_o,
   output logic          rdy_next,
   input  logic          free_next,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data_o,
   input  logic [DW-1:0] mem_data_i,
   output logic          mem_we,
   output logic          mem_req,
   input  logic          mem_ack
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      HOLD   = 2'd2
   } state_t;

   // The counter value at which the next ack-less edge aborts the access.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t        state;
   logic [7:0]    cnt;
   logic [DW-1:0] addr_src;
   logic [AW-1:0] sel_addr;

   assign addr_src = addr_sel ? ar_i : ibr_i;

   // Fit the DW-bit address source onto the AW-bit memory address.
   generate
      if (AW > DW) begin : g_zext
         assign sel_addr = {{(AW-DW){1'b0}}, addr_src};
      end else begin : g_trunc
         assign sel_addr = addr_src[AW-1:0];
      end
   endgenerate

   assign free = (state == IDLE);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         pc_o       <= '0;
         ar_o       <= '0;
         ir_o       <= '0;
         ibr_o      <= '0;
         rd_data_o  <= '0;
         err_o      <= 1'b0;
         rdy_next   <= 1'b0;
         mem_addr   <= '0;
         mem_data_o <= '0;
         mem_we     <= 1'b0;
         mem_req    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rdy) begin
                  pc_o      <= pc_i;
                  ar_o      <= ar_i;
                  ir_o      <= ir_i;
                  ibr_o     <= ibr_i;
                  err_o     <= 1'b0;
                  rd_data_o <= '0;
                  cnt       <= '0;
                  if (mem_read && mem_write) begin
                     err_o    <= 1'b1;
                     rdy_next <= 1'b1;
                     state    <= HOLD;
                  end else if (mem_read || mem_write) begin
                     mem_req    <= 1'b1;
                     mem_we     <= mem_write;
                     mem_addr   <= sel_addr;
                     mem_data_o <= ar_i;
                     state      <= ACCESS;
                  end else begin
                     rdy_next <= 1'b1;
                     state    <= HOLD;
                  end
               end
            end
            ACCESS: begin
               // An ack takes priority over a timeout on the same edge.
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  if (!mem_we) begin
                     rd_data_o <= mem_data_i;
                  end
                  rdy_next <= 1'b1;
                  state    <= HOLD;
               end else if (cnt == TO_LAST) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  err_o     <= 1'b1;
                  rd_data_o <= '0;
                  rdy_next  <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            HOLD: begin
               if (free_next) begin
                  rdy_next <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam int TMO = 4;

   logic       clk;
   logic       arst_n;
   logic       rdy;
   logic       free;
   logic [7:0] pc_i, ar_i, ir_i, ibr_i;
   logic       mem_read, mem_write, addr_sel;
   logic [7:0] pc_o, ar_o, ir_o, ibr_o, rd_data_o;
   logic       err_o, rdy_next, free_next;
   logic [7:0] mem_addr, mem_data_o, mem_data_i;
   logic       mem_we, mem_req, mem_ack;

   int total = 0;
   int bad   = 0;

   mem_stage #(.DW(8), .AW(8), .TIMEOUT(TMO)) dut (
      .clk(clk), .arst_n(arst_n), .rdy(rdy), .free(free),
      .pc_i(pc_i), .ar_i(ar_i), .ir_i(ir_i), .ibr_i(ibr_i),
      .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
      .pc_o(pc_o), .ar_o(ar_o), .ir_o(ir_o), .ibr_o(ibr_o),
      .rd_data_o(rd_data_o), .err_o(err_o), .rdy_next(rdy_next),
      .free_next(free_next), .mem_addr(mem_addr), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_we(mem_we), .mem_req(mem_req),
      .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
      $fatal(1);
   end

   typedef struct {
      logic       rd, wr, asel;
      logic [7:0] pc, ar, ir, ibr, rdat;
      int         dly;   // ACCESS cycles before ack (>= TMO means never in time)
      int         hold;  // cycles free_next stays low once rdy_next is up
   } stim_t;

   typedef struct {
      logic       err;
      logic [7:0] rd_data;
      logic [7:0] addr;
      logic       we;
      int         lat;     // edges from accept to rdy_next, accept edge included
      int         reqcyc;  // cycles with mem_req high
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic stim_t mk(input logic rd, input logic wr, input logic asel,
                                input logic [7:0] pc, input logic [7:0] ar,
                                input logic [7:0] ir, input logic [7:0] ibr,
                                input logic [7:0] rdat, input int dly, input int hold);
      stim_t s;
      s.rd = rd; s.wr = wr; s.asel = asel;
      s.pc = pc; s.ar = ar; s.ir = ir; s.ibr = ibr; s.rdat = rdat;
      s.dly = dly; s.hold = hold;
      return s;
   endfunction

   // Transaction-level reference: outcome follows directly from op class and ack delay.
   function automatic exp_t model(input stim_t s);
      exp_t e;
      e.addr    = s.asel ? s.ar : s.ibr;
      e.we      = s.wr;
      e.rd_data = 8'h00;
      e.err     = 1'b0;
      e.lat     = 1;
      e.reqcyc  = 0;
      if (s.rd && s.wr) begin
         e.err = 1'b1;
      end else if (s.rd || s.wr) begin
         if (s.dly < TMO) begin
            e.lat    = s.dly + 2;
            e.reqcyc = s.dly + 1;
            if (s.rd) e.rd_data = s.rdat;
         end else begin
            e.lat    = TMO + 1;
            e.reqcyc = TMO;
            e.err    = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic run_txn(input stim_t s, input exp_t e, input string tag);
      int         lat, reqc, wc;
      logic [7:0] a0, d0;
      logic       w0, stable, got, held;
      lat = 0; reqc = 0; wc = 0; stable = 1'b1; got = 1'b0; held = 1'b1;
      a0 = 8'h00; d0 = 8'h00; w0 = 1'b0;
      @(negedge clk);
      chk({tag, ".free_idle"}, free, 1);
      rdy = 1'b1; pc_i = s.pc; ar_i = s.ar; ir_i = s.ir; ibr_i = s.ibr;
      mem_read = s.rd; mem_write = s.wr; addr_sel = s.asel;
      mem_data_i = s.rdat; mem_ack = 1'b0; free_next = (s.hold == 0);
      @(negedge clk);
      lat = 1;
      rdy = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rdy_next) begin
            got = 1'b1;
            break;
         end
         if (mem_req) begin
            if (reqc == 0) begin
               a0 = mem_addr; d0 = mem_data_o; w0 = mem_we;
            end else if (mem_addr !== a0 || mem_data_o !== d0 || mem_we !== w0) begin
               stable = 1'b0;
            end
            reqc++;
         end
         mem_ack = (wc == s.dly);
         wc++;
         @(negedge clk);
         lat++;
      end
      mem_ack = 1'b0;
      chk({tag, ".rdy_next_seen"}, got, 1);
      if (!got) begin
         free_next = 1'b1;
         return;
      end
      chk({tag, ".latency"}, lat, e.lat);
      chk({tag, ".err_o"}, err_o, e.err);
      chk({tag, ".rd_data_o"}, rd_data_o, e.rd_data);
      chk({tag, ".regs"}, {pc_o, ar_o, ir_o, ibr_o}, {s.pc, s.ar, s.ir, s.ibr});
      chk({tag, ".req_we_free_in_hold"}, {mem_req, mem_we, free}, 3'b000);
      chk({tag, ".req_cycles"}, reqc, e.reqcyc);
      if (e.reqcyc != 0) begin
         chk({tag, ".mem_addr"}, a0, e.addr);
         chk({tag, ".mem_we"}, w0, e.we);
         chk({tag, ".mem_data_o"}, d0, s.ar);
         chk({tag, ".port_stable"}, stable, 1);
      end
      for (int i = 0; i < s.hold; i++) begin
         @(negedge clk);
         if (rdy_next !== 1'b1 || ir_o !== s.ir || err_o !== e.err ||
             rd_data_o !== e.rd_data || free !== 1'b0)
            held = 1'b0;
      end
      chk({tag, ".held"}, held, 1);
      free_next = 1'b1;
      @(negedge clk);
      chk({tag, ".release"}, {rdy_next, free}, 2'b01);
   endtask

   vec_t  tbl[8];
   stim_t rs;
   logic  quiet;

   initial begin
      arst_n = 1'b0; rdy = 1'b0; free_next = 1'b1;
      pc_i = 8'h00; ar_i = 8'h00; ir_i = 8'h00; ibr_i = 8'h00;
      mem_read = 1'b0; mem_write = 1'b0; addr_sel = 1'b0;
      mem_data_i = 8'h00; mem_ack = 1'b0;

      //               rd wr as  pc     ar     ir     ibr    rdat  dly hold      err rd_data addr we lat req
      tbl[0] = '{mk(0, 0, 0, 8'h01, 8'h22, 8'h10, 8'h33, 8'h00, 0, 0), '{0, 8'h00, 8'h00, 0, 1, 0}};
      tbl[1] = '{mk(1, 0, 0, 8'h02, 8'h55, 8'h20, 8'h3C, 8'hA5, 3, 0), '{0, 8'hA5, 8'h3C, 0, 5, 4}};
      tbl[2] = '{mk(0, 1, 1, 8'h03, 8'h7F, 8'h30, 8'h11, 8'hEE, 0, 0), '{0, 8'h00, 8'h7F, 1, 2, 1}};
      tbl[3] = '{mk(1, 0, 0, 8'h04, 8'h66, 8'h40, 8'h42, 8'h99, 99, 0), '{1, 8'h00, 8'h42, 0, 5, 4}};
      tbl[4] = '{mk(1, 1, 1, 8'h05, 8'h77, 8'h50, 8'h88, 8'h12, 0, 0), '{1, 8'h00, 8'h00, 0, 1, 0}};
      tbl[5] = '{mk(0, 1, 0, 8'h06, 8'hC3, 8'h60, 8'h80, 8'h34, 2, 2), '{0, 8'h00, 8'h80, 1, 4, 3}};
      tbl[6] = '{mk(1, 0, 1, 8'h07, 8'h9A, 8'h70, 8'h01, 8'h5E, 0, 0), '{0, 8'h5E, 8'h9A, 0, 2, 1}};
      tbl[7] = '{mk(0, 1, 1, 8'h08, 8'hB4, 8'h80, 8'h02, 8'hFF, 7, 1), '{1, 8'h00, 8'hB4, 1, 5, 4}};

      #3;
      chk("reset_state",
          {mem_req, mem_we, rdy_next, err_o, free, pc_o, ar_o, ir_o, ibr_o, rd_data_o, mem_addr, mem_data_o},
          {5'b00001, 56'h0});
      @(negedge clk);
      @(negedge clk);
      arst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_txn(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));

      // Backpressure: result held, new rdy ignored, ack in HOLD ignored.
      @(negedge clk);
      free_next = 1'b0; rdy = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      pc_i = 8'h21; ar_i = 8'h43; ir_i = 8'h5A; ibr_i = 8'h65;
      @(negedge clk);
      chk("bp.accept", {rdy_next, ir_o}, {1'b1, 8'h5A});
      ir_i = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         mem_ack = 1'b1; mem_data_i = 8'hFF;
         @(negedge clk);
         chk("bp.hold", {rdy_next, free, mem_req, rd_data_o, ir_o}, {1'b1, 1'b0, 1'b0, 8'h00, 8'h5A});
      end
      mem_ack = 1'b0; ir_i = 8'h77; free_next = 1'b1;
      @(negedge clk);
      chk("bp.release", {rdy_next, free, ir_o}, {1'b0, 1'b1, 8'h5A});
      @(negedge clk);
      chk("bp.next_accept", {rdy_next, ir_o}, {1'b1, 8'h77});
      rdy = 1'b0;
      @(negedge clk);
      chk("bp.idle_again", free, 1);

      // Ack while IDLE has no effect.
      quiet = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_ack = 1'b1; mem_data_i = 8'hAB;
         @(negedge clk);
         if (mem_req !== 1'b0 || rdy_next !== 1'b0 || free !== 1'b1 || rd_data_o !== 8'h00) quiet = 1'b0;
      end
      mem_ack = 1'b0;
      chk("idle_ack_ignored", quiet, 1);

      // Reset in the middle of a write access.
      rdy = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr_sel = 1'b1;
      pc_i = 8'h09; ar_i = 8'hC7; ir_i = 8'h99; ibr_i = 8'h5B;
      @(negedge clk);
      rdy = 1'b0;
      chk("rst.in_access", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 8'hC7});
      @(negedge clk);
      #2 arst_n = 1'b0;
      #1;
      chk("rst.async_clear",
          {mem_req, mem_we, rdy_next, err_o, free, pc_o, ar_o, ir_o, ibr_o, rd_data_o, mem_addr, mem_data_o},
          {5'b00001, 56'h0});
      @(negedge clk);
      #2 arst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rdy_next !== 1'b0 || mem_req !== 1'b0 || free !== 1'b1) quiet = 1'b0;
      end
      chk("rst.discarded", quiet, 1);
      run_txn(tbl[1].s, tbl[1].e, "rst.resume");

      // Randomized transactions against the reference model.
      for (int i = 0; i < 60; i++) begin
         int op;
         op = int'($urandom_range(0, 7));
         rs.rd   = (op == 1 || op == 2 || op == 3 || op == 7);
         rs.wr   = (op == 4 || op == 5 || op == 6 || op == 7);
         rs.asel = 1'($urandom_range(0, 1));
         rs.pc   = 8'($urandom); rs.ar  = 8'($urandom);
         rs.ir   = 8'($urandom); rs.ibr = 8'($urandom);
         rs.rdat = 8'($urandom);
         rs.dly  = int'($urandom_range(0, 6));
         rs.hold = int'($urandom_range(0, 3));
         run_txn(rs, model(rs), $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
